// File: rtl/add_share_arbiter.sv
// rtl/add_share_arbiter.sv - two-requester round-robin front end for one shared 32-bit adder
//
// Purpose:
//   Grants one of two operand requesters onto an external shared 32-bit
//   ripple-carry adder. The granted operands are driven on add_a/add_b and held
//   for ADD_LAT cycles. Then {Cout, Sum} is captured and returned, zero-extended
//   to 40 bits, on a valid/ready response channel tagged with the requester ID.
//
// Parameters:
//   ADD_LAT     cycles the operands are held before the sum is sampled (1..15)
//
// Ports:
//   clk         clock, rising edge
//   nRST        synchronous active-low reset
//   req0_valid  requester 0 has an operand pair
//   req0_a/b    requester 0 operands (32 bits each)
//   req0_ready  requester 0 accepted this cycle when req0_valid is high
//   req1_*      same set of signals for requester 1
//   add_a/b     registered operands to the shared adder (32 bits each)
//   add_sum     adder result {Cout, Sum[31:0]} (33 bits)
//   rsp_valid   result available
//   rsp_id      requester that owns the result
//   rsp_result  {7'b0, Cout, Sum} (40 bits)
//   rsp_ready   consumer accepts the result

module add_share_arbiter #(
  parameter int unsigned ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [32:0] add_sum,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [39:0] rsp_result,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // The counter counts down to zero, and the sum is sampled on the zero edge.
  // Loading ADD_LAT-1 therefore gives ADD_LAT edges from accept to capture.
  localparam logic [3:0] LAT_LOAD = 4'(ADD_LAT - 1);

  state_t      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] add_a_q,      add_a_d;
  logic [31:0] add_b_q,      add_b_d;
  logic        rsp_valid_q,  rsp_valid_d;
  logic        rsp_id_q,     rsp_id_d;
  logic [39:0] rsp_result_q, rsp_result_d;

  logic grant0;
  logic grant1;

  // A lone valid always wins. When both are valid, the requester that was
  // not granted last wins, so contended grants alternate.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;

    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          add_a_d      = req0_a;
          add_b_d      = req0_b;
          rsp_id_d     = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = LAT_LOAD;
          state_d      = ISSUE;
        end else if (grant1) begin
          add_a_d      = req1_a;
          add_b_d      = req1_b;
          rsp_id_d     = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = LAT_LOAD;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = {7'b0, add_sum};
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        // The block returns to IDLE here. A new request can only be accepted
        // on a later edge.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      add_a_q      <= 32'd0;
      add_b_q      <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 40'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb/tb_add_share_arbiter.sv - randomized self-checking bench for add_share_arbiter

module tb_add_share_arbiter;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] add_a, add_b;
  logic [32:0] add_sum;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [39:0] rsp_result;

  always #5 clk = ~clk;

  // The external shared adder.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  add_share_arbiter #(.ADD_LAT(LAT)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Values driven onto the DUT inputs.
  logic        d_v0 = 0, d_v1 = 0, d_rr = 1, d_rstn = 0;
  logic        hold0 = 0, hold1 = 0;
  logic [31:0] d_a0 = 0, d_b0 = 0, d_a1 = 0, d_b1 = 0;

  // Reference model. It tracks the transaction at the level of: "is a job
  // outstanding, when is its result due, and is the result being offered?"
  logic        known = 0;
  logic        m_busy = 0, m_rv = 0, m_id = 0, m_last = 1;
  logic [31:0] m_a = 0, m_b = 0;
  logic [39:0] m_res = 0;
  int          cyc = 0, due = 0;

  // Grants and completed responses observed at the DUT pins.
  int          glog[$];
  int          rid_log[$];
  logic [39:0] rres_log[$];

  task automatic step();
    logic exp_r0, exp_r1;
    @(negedge clk);
    req0_valid = d_v0; req0_a = d_a0; req0_b = d_b0;
    req1_valid = d_v1; req1_a = d_a1; req1_b = d_b1;
    rsp_ready  = d_rr; nRST = d_rstn;
    #1;
    exp_r0 = !m_busy && d_v0 && (!d_v1 || m_last);
    exp_r1 = !m_busy && d_v1 && (!d_v0 || !m_last);
    if (known) begin
      check("req0_ready", req0_ready, exp_r0);
      check("req1_ready", req1_ready, exp_r1);
      check("ready_both", req0_ready && req1_ready, 1'b0);
      check("rsp_valid",  rsp_valid, m_rv);
      check("rsp_id",     rsp_id, m_id);
      check("rsp_result", rsp_result, m_res);
      check("add_a",      add_a, m_a);
      check("add_b",      add_b, m_b);
    end
    if (nRST && req0_valid && req0_ready) glog.push_back(0);
    if (nRST && req1_valid && req1_ready) glog.push_back(1);
    if (nRST && rsp_valid && rsp_ready) begin
      rid_log.push_back(int'(rsp_id));
      rres_log.push_back(rsp_result);
    end
    @(posedge clk);
    cyc++;
    if (!d_rstn) begin
      known = 1; m_busy = 0; m_rv = 0; m_id = 0; m_last = 1;
      m_a = 0; m_b = 0; m_res = 0;
    end else if (known) begin
      if (exp_r0) begin
        m_busy = 1; m_id = 0; m_last = 0; m_a = d_a0; m_b = d_b0; due = cyc + LAT;
        if (!hold0) d_v0 = 0;
      end else if (exp_r1) begin
        m_busy = 1; m_id = 1; m_last = 1; m_a = d_a1; m_b = d_b1; due = cyc + LAT;
        if (!hold1) d_v1 = 0;
      end else if (m_rv && d_rr) begin
        m_rv = 0; m_busy = 0;
      end else if (m_busy && !m_rv && cyc == due) begin
        m_rv  = 1;
        m_res = {7'b0, {1'b0, m_a} + {1'b0, m_b}};
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int ones;
  int seen;
  int n_before;

  initial begin
    // Reset.
    d_rstn = 0; steps(2); d_rstn = 1;

    // Single request from requester 0.
    d_a0 = 32'h5; d_b0 = 32'h3; d_v0 = 1; d_rr = 1;
    steps(LAT + 3);
    check("s1_count", rid_log.size(), 1);
    if (rid_log.size() >= 1) begin
      check("s1_id",  rid_log[0], 0);
      check("s1_res", rres_log[0], 40'h00_0000_0008);
    end

    // Result with a carry out, from requester 1.
    d_a1 = 32'hFFFF_FFFF; d_b1 = 32'h1; d_v1 = 1;
    steps(LAT + 3);
    check("s2_count", rid_log.size(), 2);
    if (rid_log.size() >= 2) begin
      check("s2_id",  rid_log[1], 1);
      check("s2_res", rres_log[1], 40'h01_0000_0000);
    end

    // Contention after a fresh reset, with both valids held.
    d_rstn = 0; step(); d_rstn = 1;
    glog.delete();
    hold0 = 1; hold1 = 1; d_v0 = 1; d_v1 = 1;
    for (int i = 0; i < 4 * (LAT + 2); i++) begin
      d_a0 = $urandom; d_b0 = $urandom; d_a1 = $urandom; d_b1 = $urandom;
      step();
    end
    hold0 = 0; hold1 = 0; d_v0 = 0; d_v1 = 0;
    steps(LAT + 3);
    check("s3_grants_ge4", glog.size() >= 4, 1'b1);
    if (glog.size() >= 4) begin
      check("s3_g0", glog[0], 0);
      check("s3_g1", glog[1], 1);
      check("s3_g2", glog[2], 0);
      check("s3_g3", glog[3], 1);
    end

    // Backpressure: hold rsp_ready low while the result is pending.
    d_rr = 0; d_a0 = 32'h8000_0000; d_b0 = 32'h8000_0000; d_v0 = 1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (rsp_valid) seen = 1;
    end
    check("s4_rsp_seen", seen, 1);
    n_before = rid_log.size();
    steps(5);
    check("s4_no_handshake", rid_log.size(), n_before);
    d_rr = 1;
    steps(3);
    check("s4_handshake", rid_log.size(), n_before + 1);

    // Reset during ISSUE, when the counter is 2.
    d_a0 = 32'h1234; d_b0 = 32'h1; d_v0 = 1;
    step();                 // accept edge
    step();                 // counter reaches 2
    d_rstn = 0; step(); d_rstn = 1;
    n_before = rid_log.size();
    steps(LAT + 3);
    check("s5_no_rsp", rid_log.size(), n_before);
    glog.delete();
    d_v0 = 1; d_v1 = 1;
    steps(LAT + 3);
    d_v1 = 0;
    steps(LAT + 4);
    check("s5_grant_nonempty", glog.size() > 0, 1'b1);
    if (glog.size() > 0) check("s5_first_grant", glog[0], 0);

    // Valid withdrawal while busy.
    glog.delete();
    d_v0 = 1; d_a0 = 32'h77; d_b0 = 32'h11;
    step();
    d_v1 = 1; d_a1 = 32'hDEAD; step(); d_v1 = 0;
    steps(LAT + 4);
    d_v0 = 1; d_a0 = 32'h2; d_b0 = 32'h2;
    steps(LAT + 4);
    ones = 0;
    foreach (glog[i]) if (glog[i] == 1) ones++;
    check("s6_req1_never", ones, 0);
    check("s6_last_id", rid_log[rid_log.size() - 1], 0);
    check("s6_last_res", rres_log[rres_log.size() - 1], 40'h4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!d_v0 && $urandom_range(0, 2) == 0) begin
        d_v0 = 1; hold0 = $urandom_range(0, 1) == 1;
        d_a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        d_b0 = $urandom;
      end
      if (!d_v1 && $urandom_range(0, 2) == 0) begin
        d_v1 = 1; hold1 = $urandom_range(0, 1) == 1;
        d_a1 = $urandom;
        d_b1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      if ($urandom_range(0, 9) == 0) begin
        d_v0 = 0; hold0 = 0;
      end
      d_rr   = $urandom_range(0, 3) != 0;
      d_rstn = $urandom_range(0, 199) != 0;
      step();
      d_rstn = 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
